// File: rtl/alu_if.sv
// Operation issue and result broadcast bundle between the reservation
// station side and the single-cycle ALU.
interface alu_if;
  // Issue side (reservation station -> ALU)
  logic        work_en;
  logic [3:0]  rob_id_from_rs;
  logic [5:0]  opcode_from_rs;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] imm_from_rs;
  logic [31:0] pc_from_rs;

  // Result broadcast (ALU -> RS / LSB / ROB)
  logic        is_alu_ok;
  logic [3:0]  rob_id_from_alu;
  logic [31:0] res_from_alu;
  logic        is_branch_from_alu;
  logic        br_taken_from_alu;
  logic [31:0] next_pc_from_alu;

  modport master (
    output work_en, rob_id_from_rs, opcode_from_rs, val1, val2,
           imm_from_rs, pc_from_rs,
    input  is_alu_ok, rob_id_from_alu, res_from_alu, is_branch_from_alu,
           br_taken_from_alu, next_pc_from_alu
  );

  modport slave (
    input  work_en, rob_id_from_rs, opcode_from_rs, val1, val2,
           imm_from_rs, pc_from_rs,
    output is_alu_ok, rob_id_from_alu, res_from_alu, is_branch_from_alu,
           br_taken_from_alu, next_pc_from_alu
  );
endinterface

// File: rtl/alu.sv
// Single-cycle integer execution unit: computes ALU results, resolves
// branches/jumps and broadcasts the result one cycle after issue.
module alu (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  alu_if.slave bus
);

  localparam logic [5:0] OP_LUI   = 6'd0;
  localparam logic [5:0] OP_AUIPC = 6'd1;
  localparam logic [5:0] OP_JAL   = 6'd2;
  localparam logic [5:0] OP_JALR  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BGE   = 6'd7;
  localparam logic [5:0] OP_BLTU  = 6'd8;
  localparam logic [5:0] OP_BGEU  = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd21;
  localparam logic [5:0] OP_SLTI  = 6'd22;
  localparam logic [5:0] OP_SLTIU = 6'd23;
  localparam logic [5:0] OP_XORI  = 6'd24;
  localparam logic [5:0] OP_ORI   = 6'd25;
  localparam logic [5:0] OP_ANDI  = 6'd26;
  localparam logic [5:0] OP_SLLI  = 6'd27;
  localparam logic [5:0] OP_SRLI  = 6'd28;
  localparam logic [5:0] OP_SRAI  = 6'd29;
  localparam logic [5:0] OP_ADD   = 6'd30;
  localparam logic [5:0] OP_SUB   = 6'd31;
  localparam logic [5:0] OP_SLL   = 6'd32;
  localparam logic [5:0] OP_SLT   = 6'd33;
  localparam logic [5:0] OP_SLTU  = 6'd34;
  localparam logic [5:0] OP_XOR   = 6'd35;
  localparam logic [5:0] OP_SRL   = 6'd36;
  localparam logic [5:0] OP_SRA   = 6'd37;
  localparam logic [5:0] OP_OR    = 6'd38;
  localparam logic [5:0] OP_AND   = 6'd39;

  // Output registers
  logic        ok_q;
  logic [3:0]  rob_id_q;
  logic [31:0] res_q,   res_d;
  logic        br_q,    br_d;
  logic        taken_q, taken_d;
  logic [31:0] npc_q,   npc_d;

  // Shared operand / address arithmetic
  logic        use_imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_target;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign use_imm     = (bus.opcode_from_rs >= OP_ADDI) && (bus.opcode_from_rs <= OP_SRAI);
  assign op_a        = bus.val1;
  assign op_b        = use_imm ? bus.imm_from_rs : bus.val2;
  assign shamt       = op_b[4:0];
  assign pc_plus4    = bus.pc_from_rs + 32'd4;
  assign pc_plus_imm = bus.pc_from_rs + bus.imm_from_rs;
  assign jalr_target = (bus.val1 + bus.imm_from_rs) & ~32'd1;
  // Comparisons against op_b serve both SLT* (immediate or rs2) and
  // branches (always rs2, since branch opcodes select val2).
  assign lt_s        = $signed(op_a) < $signed(op_b);
  assign lt_u        = op_a < op_b;
  assign eq          = op_a == op_b;

  // Result, branch resolution and next PC for the presented op
  always_comb begin
    res_d   = 32'd0;
    br_d    = 1'b0;
    taken_d = 1'b0;
    npc_d   = pc_plus4;
    case (bus.opcode_from_rs)
      OP_LUI:   res_d = bus.imm_from_rs;
      OP_AUIPC: res_d = pc_plus_imm;
      OP_JAL: begin
        res_d   = pc_plus4;
        br_d    = 1'b1;
        taken_d = 1'b1;
        npc_d   = pc_plus_imm;
      end
      OP_JALR: begin
        res_d   = pc_plus4;
        br_d    = 1'b1;
        taken_d = 1'b1;
        npc_d   = jalr_target;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        br_d = 1'b1;
        case (bus.opcode_from_rs)
          OP_BEQ:  taken_d = eq;
          OP_BNE:  taken_d = !eq;
          OP_BLT:  taken_d = lt_s;
          OP_BGE:  taken_d = !lt_s;
          OP_BLTU: taken_d = lt_u;
          default: taken_d = !lt_u;
        endcase
        npc_d = taken_d ? pc_plus_imm : pc_plus4;
      end
      OP_ADDI, OP_ADD:  res_d = op_a + op_b;
      OP_SUB:           res_d = op_a - op_b;
      OP_SLTI, OP_SLT:  res_d = {31'd0, lt_s};
      OP_SLTIU, OP_SLTU: res_d = {31'd0, lt_u};
      OP_XORI, OP_XOR:  res_d = op_a ^ op_b;
      OP_ORI, OP_OR:    res_d = op_a | op_b;
      OP_ANDI, OP_AND:  res_d = op_a & op_b;
      OP_SLLI, OP_SLL:  res_d = op_a << shamt;
      OP_SRLI, OP_SRL:  res_d = op_a >> shamt;
      OP_SRAI, OP_SRA:  res_d = $unsigned($signed(op_a) >>> shamt);
      // Reserved opcodes still retire with a zero result
      default: res_d = 32'd0;
    endcase
  end

  // Register the broadcast; flush wins over stall, stall freezes everything
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ok_q     <= 1'b0;
      rob_id_q <= 4'd0;
      res_q    <= 32'd0;
      br_q     <= 1'b0;
      taken_q  <= 1'b0;
      npc_q    <= 32'd0;
    end else if (rdy) begin
      ok_q <= bus.work_en;
      if (bus.work_en) begin
        rob_id_q <= bus.rob_id_from_rs;
        res_q    <= res_d;
        br_q     <= br_d;
        taken_q  <= taken_d;
        npc_q    <= npc_d;
      end
    end
  end

  assign bus.is_alu_ok          = ok_q;
  assign bus.rob_id_from_alu    = rob_id_q;
  assign bus.res_from_alu       = res_q;
  assign bus.is_branch_from_alu = br_q;
  assign bus.br_taken_from_alu  = taken_q;
  assign bus.next_pc_from_alu   = npc_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: hand-computed results, branch
// resolution, back-to-back issue, clear and rdy stall behaviour.
module tb_alu;
  logic clk;
  logic rst;
  logic rdy;
  logic clear;
  int   vectors_applied;
  int   miscompares;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] rob,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.work_en        = 1'b1;
    bus.opcode_from_rs = op;
    bus.rob_id_from_rs = rob;
    bus.val1           = v1;
    bus.val2           = v2;
    bus.imm_from_rs    = imm;
    bus.pc_from_rs     = pc;
  endtask

  // Issue one op, clock it in, and stop presenting it
  task automatic run_op(input logic [5:0] op, input logic [3:0] rob,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc);
    drive(op, rob, v1, v2, imm, pc);
    tick();
    bus.work_en = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] rob,
                              input logic [31:0] res, input logic br,
                              input logic taken, input logic [31:0] npc);
    check_value({tag, ".ok"},    {31'd0, bus.is_alu_ok}, 32'd1);
    check_value({tag, ".rob"},   {28'd0, bus.rob_id_from_alu}, {28'd0, rob});
    check_value({tag, ".res"},   bus.res_from_alu, res);
    check_value({tag, ".br"},    {31'd0, bus.is_branch_from_alu}, {31'd0, br});
    check_value({tag, ".taken"}, {31'd0, bus.br_taken_from_alu}, {31'd0, taken});
    check_value({tag, ".npc"},   bus.next_pc_from_alu, npc);
    $display("op %s rob=%0d res=%h br=%0d taken=%0d npc=%h", tag,
             bus.rob_id_from_alu, bus.res_from_alu, bus.is_branch_from_alu,
             bus.br_taken_from_alu, bus.next_pc_from_alu);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst   = 1'b1;
    rdy   = 1'b1;
    clear = 1'b0;
    bus.work_en        = 1'b0;
    bus.opcode_from_rs = 6'd0;
    bus.rob_id_from_rs = 4'd0;
    bus.val1           = 32'd0;
    bus.val2           = 32'd0;
    bus.imm_from_rs    = 32'd0;
    bus.pc_from_rs     = 32'd0;
    tick();
    tick();

    // Reset state
    check_value("rst.ok",    {31'd0, bus.is_alu_ok}, 32'd0);
    check_value("rst.rob",   {28'd0, bus.rob_id_from_alu}, 32'd0);
    check_value("rst.res",   bus.res_from_alu, 32'd0);
    check_value("rst.br",    {31'd0, bus.is_branch_from_alu}, 32'd0);
    check_value("rst.taken", {31'd0, bus.br_taken_from_alu}, 32'd0);
    check_value("rst.npc",   bus.next_pc_from_alu, 32'd0);
    rst = 1'b0;
    tick();

    // ADD then idle
    run_op(6'd30, 4'd3, 32'd5, 32'd7, 32'd0, 32'h40);
    check_result("ADD", 4'd3, 32'd12, 1'b0, 1'b0, 32'h44);
    tick();
    check_value("ADD.drop", {31'd0, bus.is_alu_ok}, 32'd0);

    // Arithmetic corners
    run_op(6'd31, 4'd4, 32'd0, 32'd1, 32'd0, 32'h0);
    check_result("SUB", 4'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h4);
    run_op(6'd37, 4'd5, 32'h8000_0000, 32'h21, 32'd0, 32'h0);
    check_result("SRA", 4'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h4);
    run_op(6'd36, 4'd5, 32'h8000_0000, 32'h1F, 32'd0, 32'h0);
    check_result("SRL", 4'd5, 32'h0000_0001, 1'b0, 1'b0, 32'h4);
    run_op(6'd34, 4'd6, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0);
    check_result("SLTU", 4'd6, 32'd1, 1'b0, 1'b0, 32'h4);
    run_op(6'd23, 4'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0);
    check_result("SLTIU", 4'd7, 32'd1, 1'b0, 1'b0, 32'h4);
    run_op(6'd22, 4'd7, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0);
    check_result("SLTI", 4'd7, 32'd0, 1'b0, 1'b0, 32'h4);
    run_op(6'd0, 4'd8, 32'd0, 32'd0, 32'h1234_5000, 32'h10);
    check_result("LUI", 4'd8, 32'h1234_5000, 1'b0, 1'b0, 32'h14);

    // Branches and jumps at pc=0x100, imm=0x20
    run_op(6'd6, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    check_result("BLT", 4'd9, 32'd0, 1'b1, 1'b1, 32'h120);
    run_op(6'd8, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    check_result("BLTU", 4'd9, 32'd0, 1'b1, 1'b0, 32'h104);
    run_op(6'd4, 4'd10, 32'd7, 32'd7, 32'h20, 32'h100);
    check_result("BEQ", 4'd10, 32'd0, 1'b1, 1'b1, 32'h120);
    run_op(6'd3, 4'd11, 32'h203, 32'd0, 32'd0, 32'h100);
    check_result("JALR", 4'd11, 32'h104, 1'b1, 1'b1, 32'h202);
    run_op(6'd2, 4'd12, 32'd0, 32'd0, 32'h20, 32'h100);
    check_result("JAL", 4'd12, 32'h104, 1'b1, 1'b1, 32'h120);

    // Back-to-back ADDI then AUIPC
    drive(6'd21, 4'd1, 32'd10, 32'd99, 32'd5, 32'h0);
    tick();
    check_result("ADDI", 4'd1, 32'd15, 1'b0, 1'b0, 32'h4);
    drive(6'd1, 4'd2, 32'd0, 32'd0, 32'h3000, 32'h1000);
    tick();
    bus.work_en = 1'b0;
    check_result("AUIPC", 4'd2, 32'h4000, 1'b0, 1'b0, 32'h1004);
    tick();
    check_value("B2B.drop", {31'd0, bus.is_alu_ok}, 32'd0);

    // Op presented together with clear is dropped, outputs reset
    drive(6'd30, 4'd13, 32'd1, 32'd1, 32'd0, 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.work_en = 1'b0;
    check_value("CLR.ok",  {31'd0, bus.is_alu_ok}, 32'd0);
    check_value("CLR.res", bus.res_from_alu, 32'd0);
    check_value("CLR.rob", {28'd0, bus.rob_id_from_alu}, 32'd0);
    $display("op CLR ok=%0d res=%h", bus.is_alu_ok, bus.res_from_alu);

    // Result held while rdy is low, even with a new op presented
    run_op(6'd30, 4'd5, 32'd100, 32'd200, 32'd0, 32'h0);
    check_result("STALL0", 4'd5, 32'd300, 1'b0, 1'b0, 32'h4);
    rdy = 1'b0;
    drive(6'd31, 4'd14, 32'd9, 32'd1, 32'd0, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_result($sformatf("STALL%0d", i + 1), 4'd5, 32'd300, 1'b0, 1'b0, 32'h4);
    end
    rdy = 1'b1;
    bus.work_en = 1'b0;
    tick();
    check_value("STALL.drop", {31'd0, bus.is_alu_ok}, 32'd0);

    // Reserved opcode still retires with zero result
    run_op(6'd45, 4'd15, 32'd3, 32'd4, 32'd8, 32'h200);
    check_result("RSVD", 4'd15, 32'd0, 1'b0, 1'b0, 32'h204);
    tick();
    check_value("RSVD.drop", {31'd0, bus.is_alu_ok}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
